// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC default and fetch FSM states.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; low bits are ignored.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding fetched instruction words; flush empties it in one cycle.
module inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order memory reads and buffers returned words for decode.
// Handshakes: a transfer happens in a cycle where valid and ready are both high at the rising edge.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [XLEN-1:0]  fpc;
    logic [XLEN-1:0]  deq_pc;
    logic [XLEN-1:0]  target;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    drop_next;
    logic [CW-1:0]    redirect_drop;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      in_use;
    logic             req_fire;
    logic             rsp_fire;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign target   = word_align(redirect_pc);
    assign in_use   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid;

    // In-flight reads count against buffer space so every response has a slot.
    assign imem_req_valid = (state != BOOT) && !redirect && (in_use < (CW + 1)'(BUF_DEPTH));
    assign imem_req_addr  = fpc;

    assign inst_valid = !fifo_empty && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign push       = rsp_fire && !redirect && (drop_cnt == '0) && (!fifo_full || pop);
    assign inst_pc    = deq_pc;

    // Every read still in flight at a redirect is stale, except one returning this cycle.
    assign redirect_drop = outstanding - CW'(rsp_fire);

    always_comb begin
        drop_next = drop_cnt;
        if (redirect) begin
            drop_next = redirect_drop;
        end else if (rsp_fire && (drop_cnt != '0)) begin
            drop_next = drop_cnt - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect && (redirect_drop != '0)) state_next = FLUSH;
            FLUSH:   if (drop_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fpc         <= RESET_PC;
            deq_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_next;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (redirect) begin
                fpc    <= target;
                deq_pc <= target;
            end else begin
                if (req_fire) fpc    <= fpc + 32'd4;
                if (pop)      deq_pc <= deq_pc + 32'd4;
            end
        end
    end

    inst_fifo #(
        .WIDTH (INST_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (imem_rsp_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (inst),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written corner sequences, randomized run.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    pc_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          delivered = 0;
    logic [31:0] exp_q[$];       // PCs fetched since the last redirect, not yet delivered
    logic [31:0] mq_addr[$];     // memory model: accepted addresses in order
    int          mq_due[$];
    logic [31:0] req_exp;
    bit          pop_seen;
    logic [31:0] pop_pc;
    bit          fire_seen;
    logic [31:0] fire_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"},  imem_req_addr, RESET_PC);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst_pc"},   inst_pc, RESET_PC);
        check({tag, "_inst"},      inst, 32'd0);
    endtask

    // Leaves the DUT in its BOOT cycle with outputs checked; next posedge enters RUN.
    task automatic apply_reset();
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        rst_n          = 1'b0;
        exp_q.delete();
        mq_addr.delete();
        mq_due.delete();
        req_exp = RESET_PC;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("boot");
    endtask

    // One clock cycle: drive inputs after the edge, observe at the falling edge.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rrdy, input logic irdy);
        int due;
        @(posedge clk);
        #1;
        redirect       = redir;
        redirect_pc    = rpc;
        imem_req_ready = rrdy;
        inst_ready     = irdy;
        if (mq_addr.size() > 0 && cyc >= mq_due[0]) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        pop_seen  = 1'b0;
        fire_seen = 1'b0;
        if (redir) begin
            check("redirect_no_inst_valid", 32'(inst_valid), 32'd0);
            check("redirect_no_req_valid", 32'(imem_req_valid), 32'd0);
            exp_q.delete();
            req_exp = {rpc[31:2], 2'b00};
        end else begin
            if (inst_valid && inst_ready) begin
                pop_seen = 1'b1;
                pop_pc   = inst_pc;
                delivered++;
                if (exp_q.size() == 0) begin
                    check("unexpected_delivery_pc", inst_pc, 32'hxxxx_xxxx);
                end else begin
                    check("deliver_pc", inst_pc, exp_q[0]);
                    check("deliver_inst", inst, mem_word(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, req_exp);
                if (imem_req_ready) begin
                    fire_seen = 1'b1;
                    fire_addr = imem_req_addr;
                    exp_q.push_back(req_exp);
                    req_exp = req_exp + 32'd4;
                end
            end
            check("fetched_bound", 32'(exp_q.size() <= BUF_DEPTH), 32'd1);
        end
        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + mem_lat;
            if (mq_due.size() > 0 && due < mq_due[$]) due = mq_due[$];
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
        end
        check("outstanding_bound", 32'(mq_addr.size() <= BUF_DEPTH), 32'd1);
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        irdy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        bit got;
        logic [31:0] fires[$];

        // 1-cycle memory, always ready: fill, stall on inst_ready, redirect with coincident response and pop.
        vecs[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000};
        vecs[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h008, 1'b1, 32'h000};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h004};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b0, 32'h008};
        vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 1'b1, 32'h008};
        vecs[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 1'b1, 32'h008};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h008};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h00C};
        vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h014, 1'b0, 32'h010};
        vecs[10] = '{1'b1, 32'h203, 1'b1, 1'b0, 32'h018, 1'b0, 32'h010};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h200};
        vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h200};
        vecs[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 1'b1, 32'h200};
        vecs[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h204};

        apply_reset();
        mem_lat = 1;
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].redir, vecs[i].rpc, 1'b1, vecs[i].irdy);
            check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
            check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
            check($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
            check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
            if (vecs[i].e_iv) check($sformatf("vec%0d_inst", i), inst, mem_word(vecs[i].e_ipc));
        end

        // Redirect with two reads in flight: both responses must be discarded.
        apply_reset();
        mem_lat = 4;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("two_outstanding_req_blocked", 32'(imem_req_valid), 32'd0);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("flush_state", 32'(dut.state), 32'(FLUSH));
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (pop_seen) begin
                got = 1'b1;
                check("first_after_redirect_pc", pop_pc, 32'h100);
                check("run_after_flush", 32'(dut.state), 32'(RUN));
            end
        end
        if (!got) check("first_after_redirect_timeout", 32'd0, 32'd1);

        // PC wrap at the top of the address space.
        mem_lat = 1;
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        for (int i = 0; i < 20 && fires.size() < 2; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (fire_seen) fires.push_back(fire_addr);
        end
        if (fires.size() == 2) begin
            check("wrap_first_addr", fires[0], 32'hFFFF_FFFC);
            check("wrap_second_addr", fires[1], 32'h0000_0000);
        end else begin
            check("wrap_timeout", 32'(fires.size()), 32'd2);
        end

        // Randomized traffic: variable memory latency, stalls on both sides, random redirects.
        begin
            int start_del;
            logic prev_redir;
            logic r;
            logic [31:0] target;
            start_del  = delivered;
            prev_redir = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                mem_lat = $urandom_range(1, 4);
                r = !prev_redir && ($urandom_range(0, 19) == 0);
                target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
                step(r, target, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
                prev_redir = r;
            end
            check("random_liveness", 32'((delivered - start_del) > 100), 32'd1);
        end

        // Asynchronous reset mid-stream, off the clock edge.
        mem_lat = 2;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #1 redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        apply_reset();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (fire_seen) begin
                got = 1'b1;
                check("post_reset_first_addr", fire_addr, RESET_PC);
            end
        end
        if (!got) check("post_reset_fetch_timeout", 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
